// File: rtl/stack_pkg.sv
// Shared types and constants for the stack push/pop micro-sequencer.
package stack_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t STACK_BASE_DEF  = 16'h0000;
  localparam word_t STACK_LIMIT_DEF = 16'hFF00;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PUSH_DEC  = 3'd1,
    PUSH_WR   = 3'd2,
    PUSH_UNDO = 3'd3,
    POP_RD    = 3'd4,
    POP_INC   = 3'd5,
    DONE      = 3'd6
  } state_t;

endpackage

// File: rtl/stack_seq_if.sv
// SP-control and memory-bus signals between the stack sequencer (master)
// and the SP register / memory side (slave).
interface stack_seq_if;
  import stack_pkg::*;

  word_t sp_value;
  logic  sp_dec;
  logic  sp_inc;
  logic  sp_read_abus;
  logic  mem_we;
  logic  mem_re;
  word_t mem_wdata;
  word_t mem_rdata;
  logic  mem_ready;

  modport master (
    input  sp_value, mem_rdata, mem_ready,
    output sp_dec, sp_inc, sp_read_abus, mem_we, mem_re, mem_wdata
  );

  modport slave (
    output sp_value, mem_rdata, mem_ready,
    input  sp_dec, sp_inc, sp_read_abus, mem_we, mem_re, mem_wdata
  );

endinterface

// File: rtl/stack_wait_timer.sv
// Memory wait counter: cleared outside an access, counts cycles without
// mem_ready and flags a timeout on the last allowed cycle (TIMEOUT=0 disables).
module stack_wait_timer #(
  parameter logic [7:0] TIMEOUT = 8'd15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic ready,
  output logic timeout
);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (!ready) cnt <= cnt + 8'd1;
  end

  // ready on the limit cycle wins over the timeout
  assign timeout = (TIMEOUT != 8'd0) && !clear && !ready && (cnt == TIMEOUT - 8'd1);

endmodule

// File: rtl/stack_seq.sv
// Stack PUSH/POP micro-sequencer driving SP strobes and memory strobes.
// Optional SP bounds refusal is enabled by defining STACK_BOUNDS_EN.
//
// state     | meaning
// IDLE      | waiting for push_req / pop_req
// PUSH_DEC  | pre-decrement SP
// PUSH_WR   | write latched word at SP, wait for mem_ready
// PUSH_UNDO | write timed out, increment SP back
// POP_RD    | read word at SP, wait for mem_ready
// POP_INC   | post-increment SP
// DONE      | one-cycle done pulse, err valid
module stack_seq
  import stack_pkg::*;
#(
  parameter logic [7:0] TIMEOUT     = 8'd15,
  parameter word_t      STACK_BASE  = STACK_BASE_DEF,
  parameter word_t      STACK_LIMIT = STACK_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_req,
  input  logic        pop_req,
  input  word_t       push_data,
  output word_t       pop_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  stack_seq_if.master bus
);

  state_t state, state_nx;
  word_t  data_q;
  logic   err_q, err_nx;
  logic   waiting, timeout;
  logic   refuse_push, refuse_pop;

`ifdef STACK_BOUNDS_EN
  assign refuse_push = (bus.sp_value == STACK_LIMIT);
  assign refuse_pop  = (bus.sp_value == STACK_BASE);
`else
  logic unused_bounds;
  assign unused_bounds = ^{bus.sp_value, STACK_BASE, STACK_LIMIT};
  assign refuse_push   = 1'b0;
  assign refuse_pop    = 1'b0;
`endif

  assign waiting = (state == PUSH_WR) || (state == POP_RD);

  stack_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!waiting),
    .ready   (bus.mem_ready),
    .timeout (timeout)
  );

  always_comb begin
    state_nx = state;
    err_nx   = err_q;
    case (state)
      IDLE: begin
        if (push_req) begin
          state_nx = refuse_push ? DONE : PUSH_DEC;
          err_nx   = refuse_push;
        end else if (pop_req) begin
          state_nx = refuse_pop ? DONE : POP_RD;
          err_nx   = refuse_pop;
        end
      end
      PUSH_DEC: state_nx = PUSH_WR;
      PUSH_WR: begin
        if (bus.mem_ready) begin
          state_nx = DONE;
          err_nx   = 1'b0;
        end else if (timeout) begin
          state_nx = PUSH_UNDO;
        end
      end
      PUSH_UNDO: begin
        state_nx = DONE;
        err_nx   = 1'b1;
      end
      POP_RD: begin
        if (bus.mem_ready) begin
          state_nx = POP_INC;
        end else if (timeout) begin
          state_nx = DONE;
          err_nx   = 1'b1;
        end
      end
      POP_INC: begin
        state_nx = DONE;
        err_nx   = 1'b0;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      err_q    <= 1'b0;
      data_q   <= '0;
      pop_data <= '0;
    end else begin
      state <= state_nx;
      err_q <= err_nx;
      if (state == IDLE && push_req)         data_q   <= push_data;
      if (state == POP_RD && bus.mem_ready)  pop_data <= bus.mem_rdata;
    end
  end

  assign busy             = (state != IDLE);
  assign done             = (state == DONE);
  assign err              = (state == DONE) && err_q;
  assign bus.sp_dec       = (state == PUSH_DEC);
  assign bus.sp_inc       = (state == PUSH_UNDO) || (state == POP_INC);
  assign bus.sp_read_abus = waiting;
  assign bus.mem_we       = (state == PUSH_WR);
  assign bus.mem_re       = (state == POP_RD);
  assign bus.mem_wdata    = (state == PUSH_WR) ? data_q : '0;

endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq with a behavioural SP register; TIMEOUT is set to 4.
module tb_stack_seq;
  import stack_pkg::*;

  logic  clk = 1'b0;
  logic  reset;
  logic  push_req, pop_req;
  word_t push_data;
  word_t pop_data;
  logic  busy, done, err;

  logic  sp_rst, sp_load;
  word_t sp, sp_load_val;

  int n_checks = 0;
  int n_fail   = 0;

  stack_seq_if bus ();

  stack_seq #(.TIMEOUT(8'd4)) dut (
    .clk       (clk),
    .reset     (reset),
    .push_req  (push_req),
    .pop_req   (pop_req),
    .push_data (push_data),
    .pop_data  (pop_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge sp_rst) begin
    if (sp_rst)             sp <= 16'h0000;
    else if (sp_load)       sp <= sp_load_val;
    else if (bus.sp_dec)    sp <= sp - 16'h0001;
    else if (bus.sp_inc)    sp <= sp + 16'h0001;
  end

  assign bus.sp_value = sp;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input word_t obs, input word_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; sp_rst = 1'b1; sp_load = 1'b0; sp_load_val = '0;
    push_req = 1'b0; pop_req = 1'b0; push_data = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    step(); step();
    reset = 1'b0; sp_rst = 1'b0;
    step();

    // reset state
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk16("rst_pop_data", pop_data, 16'h0000);
    chk1("rst_we", bus.mem_we, 1'b0);
    chk1("rst_re", bus.mem_re, 1'b0);
    chk1("rst_dec", bus.sp_dec, 1'b0);
    chk16("rst_wdata", bus.mem_wdata, 16'h0000);

    // push BEEF, ready on first write cycle; SP wraps 0000 -> FFFF
    push_req = 1'b1; push_data = 16'hBEEF; bus.mem_ready = 1'b1;
    step();
    chk1("p1_dec", bus.sp_dec, 1'b1);
    chk1("p1_busy", busy, 1'b1);
    chk1("p1_we_early", bus.mem_we, 1'b0);
    push_req = 1'b0; push_data = 16'h0000;
    step();
    chk1("p1_we", bus.mem_we, 1'b1);
    chk1("p1_abus", bus.sp_read_abus, 1'b1);
    chk16("p1_wdata", bus.mem_wdata, 16'hBEEF);
    chk16("p1_addr", sp, 16'hFFFF);
    step();
    chk1("p1_done", done, 1'b1);
    chk1("p1_err", err, 1'b0);
    chk1("p1_we_off", bus.mem_we, 1'b0);
    chk16("p1_wdata_off", bus.mem_wdata, 16'h0000);
    step();
    chk1("p1_done_pulse", done, 1'b0);
    chk1("p1_idle", busy, 1'b0);
    chk16("p1_sp", sp, 16'hFFFF);

    // pop with two wait cycles
    pop_req = 1'b1; bus.mem_ready = 1'b0; bus.mem_rdata = 16'hBEEF;
    step();
    chk1("o1_re", bus.mem_re, 1'b1);
    chk1("o1_abus", bus.sp_read_abus, 1'b1);
    pop_req = 1'b0;
    step();
    chk1("o1_re_wait", bus.mem_re, 1'b1);
    step();
    bus.mem_ready = 1'b1;
    step();
    chk1("o1_inc", bus.sp_inc, 1'b1);
    chk1("o1_dec_off", bus.sp_dec, 1'b0);
    chk16("o1_pop_data", pop_data, 16'hBEEF);
    chk1("o1_re_off", bus.mem_re, 1'b0);
    bus.mem_ready = 1'b0;
    step();
    chk1("o1_done", done, 1'b1);
    chk1("o1_err", err, 1'b0);
    chk16("o1_sp", sp, 16'h0000);
    step();

    // push and pop together: push wins, pop taken only after DONE
    push_req = 1'b1; pop_req = 1'b1; push_data = 16'h1234; bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'h1234;
    step();
    chk1("b_dec", bus.sp_dec, 1'b1);
    chk1("b_re_ignored", bus.mem_re, 1'b0);
    push_req = 1'b0;
    step();
    chk16("b_wdata", bus.mem_wdata, 16'h1234);
    chk1("b_re_ignored2", bus.mem_re, 1'b0);
    step();
    chk1("b_done", done, 1'b1);
    step();
    chk1("b_idle", busy, 1'b0);
    step();
    chk1("b_pop_re", bus.mem_re, 1'b1);
    pop_req = 1'b0;
    step();
    chk16("b_pop_data", pop_data, 16'h1234);
    step();
    chk1("b_pop_done", done, 1'b1);
    chk16("b_sp", sp, 16'h0000);
    step();

    // push timeout with TIMEOUT=4: four write cycles then undo
    push_req = 1'b1; push_data = 16'hCAFE; bus.mem_ready = 1'b0;
    step();
    push_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("t_we_cycle", bus.mem_we, 1'b1);
    end
    step();
    chk1("t_undo_inc", bus.sp_inc, 1'b1);
    chk1("t_we_off", bus.mem_we, 1'b0);
    step();
    chk1("t_done", done, 1'b1);
    chk1("t_err", err, 1'b1);
    chk16("t_sp_restored", sp, 16'h0000);
    step();
    chk1("t_err_clear", err, 1'b0);

`ifdef STACK_BOUNDS_EN
    // pop at an empty stack is refused without strobes
    pop_req = 1'b1; bus.mem_ready = 1'b1; bus.mem_rdata = 16'h9999;
    step();
    chk1("bd_done", done, 1'b1);
    chk1("bd_err", err, 1'b1);
    chk1("bd_re", bus.mem_re, 1'b0);
    chk1("bd_inc", bus.sp_inc, 1'b0);
    chk16("bd_pop_data", pop_data, 16'h1234);
    pop_req = 1'b0; bus.mem_ready = 1'b0;
    step();
    chk1("bd_idle", busy, 1'b0);
    chk16("bd_sp", sp, 16'h0000);
`endif

    // reset asserted during POP_RD
    sp_load = 1'b1; sp_load_val = 16'h0100;
    step();
    sp_load = 1'b0;
    pop_req = 1'b1; bus.mem_ready = 1'b0; bus.mem_rdata = 16'h5555;
    step();
    chk1("r_re", bus.mem_re, 1'b1);
    pop_req = 1'b0;
    reset = 1'b1;
    step();
    chk1("r_re_off", bus.mem_re, 1'b0);
    chk1("r_busy", busy, 1'b0);
    chk1("r_done", done, 1'b0);
    chk1("r_abus", bus.sp_read_abus, 1'b0);
    chk16("r_pop_data", pop_data, 16'h0000);
    reset = 1'b0;
    step();
    chk1("r_no_done", done, 1'b0);
    chk16("r_sp_kept", sp, 16'h0100);

    push_req = 1'b1; push_data = 16'h7777; bus.mem_ready = 1'b1;
    step();
    chk1("r_p_dec", bus.sp_dec, 1'b1);
    push_req = 1'b0;
    step();
    chk16("r_p_wdata", bus.mem_wdata, 16'h7777);
    chk16("r_p_addr", sp, 16'h00FF);
    step();
    chk1("r_p_done", done, 1'b1);
    chk1("r_p_err", err, 1'b0);
    step();
    chk1("r_p_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- Micro-sequencer that runs complete PUSH and POP transactions on the 16-bit stack.
- Drives the stack pointer's dec/inc/read_abus controls and the memory read/write strobes.
- Accepts a request from the control unit and returns a one-cycle done pulse.
- Push is pre-decrement then write; pop is read then post-increment. This matches the SP register's reset value of 16'h0000, so the first push lands at 16'hFFFF.

Parameters:
- TIMEOUT, 8'd15, max cycles to wait for mem_ready in one access; 0 = wait forever.
- STACK_BASE, 16'h0000, SP value when the stack is empty (used only with STACK_BOUNDS_EN).
- STACK_LIMIT, 16'hFF00, lowest legal SP; SP == STACK_LIMIT means full (used only with STACK_BOUNDS_EN).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- push_req  input  1  start push; sampled only in IDLE.
- pop_req  input  1  start pop; sampled only in IDLE.
- push_data  input  16  word to push; latched when push is accepted.
- pop_data  output  16  last popped word; holds until next successful pop.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse at end of every accepted request.
- err  output  1  valid with done: 1 = timeout or bounds refusal.
- sp_value  input  16  current SP register contents (direct tap).
- sp_dec  output  1  SP decrement strobe.
- sp_inc  output  1  SP increment strobe.
- sp_read_abus  output  1  SP drives address bus.
- mem_we  output  1  memory write strobe.
- mem_re  output  1  memory read strobe.
- mem_wdata  output  16  write data; 16'h0000 when mem_we is low.
- mem_rdata  input  16  read data; sampled when mem_ready is high.
- mem_ready  input  1  memory access complete this cycle.

Behaviour:
- Reset: state IDLE; all outputs 0; pop_data 16'h0000; wait counter 0. Reset mid-transaction aborts immediately with no done pulse. SP resets independently.
- IDLE: if push_req -> PUSH_DEC; else if pop_req -> POP_RD. Push has priority when both are high. Latch push_data on acceptance.
- PUSH_DEC (1 cycle): sp_dec=1 -> PUSH_WR.
- PUSH_WR:
  - sp_read_abus=1, mem_we=1, mem_wdata=latched data.
  - mem_ready -> DONE with err=0.
  - Wait counter reaching TIMEOUT -> PUSH_UNDO.
- PUSH_UNDO (1 cycle): sp_inc=1 to restore SP -> DONE with err=1.
- POP_RD:
  - sp_read_abus=1, mem_re=1.
  - mem_ready -> latch mem_rdata into pop_data -> POP_INC.
  - Timeout -> DONE with err=1; SP and pop_data unchanged.
- POP_INC (1 cycle): sp_inc=1 -> DONE with err=0.
- DONE (1 cycle): done=1, err as set -> IDLE. A request still held high is re-accepted the following cycle.
- Wait counter:
  - Cleared on entry to PUSH_WR and POP_RD; increments each cycle without mem_ready.
  - Timeout fires when counter == TIMEOUT-1 and mem_ready is low.
  - mem_ready on the same cycle as the limit counts as success.
- Minimum latency, request to done, with mem_ready on the first access cycle: push 3 cycles, pop 3 cycles.
- At most one of sp_dec/sp_inc is asserted per cycle. The SP write port is never driven.
- Requests during busy are ignored, not queued.
- SP wrap-around (16'h0000 -> 16'hFFFF) is legal without STACK_BOUNDS_EN.

Optional Feature:
- Macro: STACK_BOUNDS_EN.
- Defined:
  - In IDLE, an accepted push with sp_value == STACK_LIMIT, or an accepted pop with sp_value == STACK_BASE, goes directly to DONE with err=1.
  - No SP strobes and no memory strobes are issued; pop_data is unchanged.
- Undefined: no bounds comparators; sp_value is unused; refusal never occurs.

Decomposition:
- Shared package stack_pkg:
  - State encoding enum: IDLE, PUSH_DEC, PUSH_WR, PUSH_UNDO, POP_RD, POP_INC, DONE.
  - WORD_W = 16.
  - Default constants for STACK_BASE and STACK_LIMIT.
- One sub-module, stack_wait_timer: loadable wait counter with a timeout flag, parameterised by TIMEOUT.

Test Plan:
- Reset, push 16'hBEEF with mem_ready on first cycle -> sp_dec pulse, then a write to 16'hFFFF with mem_wdata=16'hBEEF; done with err=0 after 3 cycles; SP=16'hFFFF.
- Pop after that push with mem_rdata=16'hBEEF, ready after 2 wait cycles -> pop_data=16'hBEEF; sp_inc pulse; SP=16'h0000; done after 5 cycles.
- push_req and pop_req high together in IDLE -> push executes; pop is ignored until after DONE.
- TIMEOUT=4, push with mem_ready never high -> 4 write cycles, then sp_inc; done with err=1; SP restored to its pre-push value.
- Assert reset during POP_RD -> all outputs 0 next edge; no done pulse; subsequent push works normally.
- STACK_BOUNDS_EN defined, sp_value=STACK_BASE, pop_req -> done with err=1 after 1 cycle; no strobes; pop_data unchanged.
